// File: rtl/tlp_length_tracker.sv
// -----------------------------------------------------------------------------
// tlp_length_tracker
//
// Framing-length extractor for the 128b/130b (gen 3/4/5) receive path.
// Each cycle the byte lanes are scanned from lane 0 upward for STP/SDP/END
// markers. The DW length of every packet that closes in the cycle is reported
// one cycle later in ascending slot order. Packets may span any number of
// cycles. The data and the markers are delayed by one register stage so that
// they line up with the reported lengths.
//
// Ports
//   pclk, reset          clock; asynchronous active-high reset
//   gen                  link generation (scan enabled for 3/4/5 only)
//   data_in, wr,         symbol bytes, cycle valid, per-byte valid
//   wr_valid
//   STP_IN/SDP_IN/END_IN per-byte framing markers
//   *_out                inputs delayed by one cycle
//   length               MAX_PKTS slots of LEN_W bits; slot k = length[k*LEN_W +: LEN_W]
//   length_valid         slot k holds a packet that closed this cycle
//   in_packet            a packet is still open after the previous scan
//   pkt_count            completed packets, wraps at 16 bits
//   err_*                sticky framing errors, cleared only by reset
// -----------------------------------------------------------------------------
module tlp_length_tracker #(
  parameter int BYTES     = 64,
  parameter int MAX_PKTS  = 16,
  parameter int LEN_W     = 11,
  parameter int COUNT_SDP = 0
) (
  input  logic                      pclk,
  input  logic                      reset,
  input  logic [2:0]                gen,
  input  logic [8*BYTES-1:0]        data_in,
  input  logic                      wr,
  input  logic [BYTES-1:0]          wr_valid,
  input  logic [BYTES-1:0]          STP_IN,
  input  logic [BYTES-1:0]          SDP_IN,
  input  logic [BYTES-1:0]          END_IN,
  output logic [8*BYTES-1:0]        data_out,
  output logic                      wr_out,
  output logic [BYTES-1:0]          wr_valid_out,
  output logic [BYTES-1:0]          STP_out,
  output logic [BYTES-1:0]          SDP_out,
  output logic [BYTES-1:0]          END_out,
  output logic [MAX_PKTS*LEN_W-1:0] length,
  output logic [MAX_PKTS-1:0]       length_valid,
  output logic                      in_packet,
  output logic [15:0]               pkt_count,
  output logic                      err_no_stp,
  output logic                      err_no_end,
  output logic                      err_overflow,
  output logic                      err_too_many
);

  // Byte counter carries two extra bits so that counter>>2 is exactly LEN_W
  // bits wide; saturating the counter therefore saturates the DW length too.
  localparam int CNT_W  = LEN_W + 2;
  localparam int SLOT_W = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam int NUM_W  = $clog2(MAX_PKTS + 1);

  logic                              gen_ok;
  logic                              open_q, open_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [MAX_PKTS-1:0][LEN_W-1:0]    len_q, len_d;
  logic [MAX_PKTS-1:0]               lv_q, lv_d;
  logic [15:0]                       pcnt_q, pcnt_d;
  logic                              no_stp_q, no_stp_d;
  logic                              no_end_q, no_end_d;
  logic                              ovf_q, ovf_d;
  logic                              too_many_q, too_many_d;
  logic [NUM_W-1:0]                  slot_n;

  logic [8*BYTES-1:0]                data_q;
  logic                              wr_q;
  logic [BYTES-1:0]                  wv_q, stp_q, sdp_q, end_q;

  assign gen_ok = (gen == 3'b011) || (gen == 3'b100) || (gen == 3'b101);

  // The scan walks the lanes in order and every lane sees the open/counter
  // state left by the lane before it, so the working copies are updated in
  // place.
  // NOTE: blocking assignments here are deliberate: each loop iteration must
  // observe the previous iteration's update. Every variable is defaulted at
  // the top so no path leaves a value unassigned (which would infer a latch).
  always_comb begin
    open_d     = open_q;
    cnt_d      = cnt_q;
    len_d      = '0;
    lv_d       = '0;
    pcnt_d     = pcnt_q;
    no_stp_d   = no_stp_q;
    no_end_d   = no_end_q;
    ovf_d      = ovf_q;
    too_many_d = too_many_q;
    slot_n     = '0;

    if (!gen_ok) begin
      open_d = 1'b0;
      cnt_d  = '0;
    end else if (wr) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_valid[i]) begin
          // Start: a second start drops the packet already in flight.
          if (STP_IN[i] || ((COUNT_SDP != 0) && SDP_IN[i])) begin
            if (open_d) no_end_d = 1'b1;
            open_d = 1'b1;
            cnt_d  = '0;
          end
          // Count: the START and END lanes both belong to the packet.
          if (open_d) begin
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
            if (cnt_d == '1) ovf_d = 1'b1;
          end
          // End: report into the next free slot, or drop when all are used.
          if (END_IN[i]) begin
            if (!open_d) begin
              no_stp_d = 1'b1;
            end else begin
              if (slot_n == NUM_W'(MAX_PKTS)) begin
                too_many_d = 1'b1;
              end else begin
                len_d[slot_n[SLOT_W-1:0]] = cnt_d[CNT_W-1:2];
                lv_d[slot_n[SLOT_W-1:0]]  = 1'b1;
                slot_n                    = slot_n + 1'b1;
                pcnt_d                    = pcnt_d + 1'b1;
              end
              open_d = 1'b0;
            end
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples its inputs from before the edge, independent of process order.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      open_q     <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      lv_q       <= '0;
      pcnt_q     <= '0;
      no_stp_q   <= 1'b0;
      no_end_q   <= 1'b0;
      ovf_q      <= 1'b0;
      too_many_q <= 1'b0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      wv_q       <= '0;
      stp_q      <= '0;
      sdp_q      <= '0;
      end_q      <= '0;
    end else begin
      open_q     <= open_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      lv_q       <= lv_d;
      pcnt_q     <= pcnt_d;
      no_stp_q   <= no_stp_d;
      no_end_q   <= no_end_d;
      ovf_q      <= ovf_d;
      too_many_q <= too_many_d;
      data_q     <= data_in;
      wr_q       <= wr;
      wv_q       <= wr_valid;
      stp_q      <= STP_IN;
      sdp_q      <= SDP_IN;
      end_q      <= END_IN;
    end
  end

  assign data_out     = data_q;
  assign wr_out       = wr_q;
  assign wr_valid_out = wv_q;
  assign STP_out      = stp_q;
  assign SDP_out      = sdp_q;
  assign END_out      = end_q;
  assign length       = len_q;
  assign length_valid = lv_q;
  assign in_packet    = open_q;
  assign pkt_count    = pcnt_q;
  assign err_no_stp   = no_stp_q;
  assign err_no_end   = no_end_q;
  assign err_overflow = ovf_q;
  assign err_too_many = too_many_q;

endmodule

// File: tb/tb_tlp_length_tracker.sv
// -----------------------------------------------------------------------------
// tb_tlp_length_tracker
//
// Directed framing scenarios with fixed expectations, followed by randomized
// traffic compared against a byte-walking reference model that keeps its
// state as plain integers and its completed lengths in a queue.
// -----------------------------------------------------------------------------
module tb_tlp_length_tracker;

  localparam int BYTES    = 64;
  localparam int MAX_PKTS = 16;
  localparam int LEN_W    = 11;
  localparam int LW       = MAX_PKTS * LEN_W;
  localparam int CNT_MAX  = (1 << (LEN_W + 2)) - 1;

  logic                 pclk = 1'b0;
  logic                 reset;
  logic [2:0]           gen;
  logic [8*BYTES-1:0]   data_in;
  logic                 wr;
  logic [BYTES-1:0]     wr_valid, STP_IN, SDP_IN, END_IN;
  logic [8*BYTES-1:0]   data_out;
  logic                 wr_out;
  logic [BYTES-1:0]     wr_valid_out, STP_out, SDP_out, END_out;
  logic [LW-1:0]        length;
  logic [MAX_PKTS-1:0]  length_valid;
  logic                 in_packet;
  logic [15:0]          pkt_count;
  logic                 err_no_stp, err_no_end, err_overflow, err_too_many;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit              m_open;
  int              m_cnt;
  int              m_pkts;
  bit              m_ns, m_ne, m_ov, m_tm;
  logic [LW-1:0]   exp_len;
  logic [MAX_PKTS-1:0] exp_lv;

  always #5 pclk = ~pclk;

  tlp_length_tracker #(
    .BYTES(BYTES), .MAX_PKTS(MAX_PKTS), .LEN_W(LEN_W), .COUNT_SDP(0)
  ) dut (
    .pclk(pclk), .reset(reset), .gen(gen), .data_in(data_in), .wr(wr),
    .wr_valid(wr_valid), .STP_IN(STP_IN), .SDP_IN(SDP_IN), .END_IN(END_IN),
    .data_out(data_out), .wr_out(wr_out), .wr_valid_out(wr_valid_out),
    .STP_out(STP_out), .SDP_out(SDP_out), .END_out(END_out),
    .length(length), .length_valid(length_valid), .in_packet(in_packet),
    .pkt_count(pkt_count), .err_no_stp(err_no_stp), .err_no_end(err_no_end),
    .err_overflow(err_overflow), .err_too_many(err_too_many)
  );

  // ---------------------------------------------------------------- helpers
  task automatic idle_inputs();
    gen      = 3'b011;
    wr       = 1'b1;
    wr_valid = '1;
    STP_IN   = '0;
    SDP_IN   = '0;
    END_IN   = '0;
    data_in  = {16{$urandom()}};
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the same point, well away from the next edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Walks one cycle of input bytes in order and records what the tracker
  // must report after the next edge.
  task automatic model_cycle();
    int q[$];
    bit gen_ok;
    gen_ok = (gen == 3'd3) || (gen == 3'd4) || (gen == 3'd5);
    if (!gen_ok) begin
      m_open = 1'b0;
      m_cnt  = 0;
    end else if (wr) begin
      for (int i = 0; i < BYTES; i++) begin
        if (!wr_valid[i]) continue;
        if (STP_IN[i]) begin
          if (m_open) m_ne = 1'b1;
          m_open = 1'b1;
          m_cnt  = 0;
        end
        if (m_open) begin
          m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
          if (m_cnt == CNT_MAX) m_ov = 1'b1;
        end
        if (END_IN[i]) begin
          if (!m_open) m_ns = 1'b1;
          else begin
            if (q.size() == MAX_PKTS) m_tm = 1'b1;
            else begin
              q.push_back(m_cnt / 4);
              m_pkts = (m_pkts + 1) % 65536;
            end
            m_open = 1'b0;
          end
        end
      end
    end
    exp_len = '0;
    exp_lv  = '0;
    foreach (q[k]) begin
      exp_len[k*LEN_W +: LEN_W] = LEN_W'(q[k]);
      exp_lv[k] = 1'b1;
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    idle_inputs();
    STP_IN[3] = 1'b1;
    step();
    reset = 1'b1;
    #1;
    n_total++;
    if ({data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out, length, length_valid,
         in_packet, pkt_count, err_no_stp, err_no_end, err_overflow, err_too_many} !== '0)
      $display("FAIL reset_outputs: some output nonzero (in_packet=%0b wr_out=%0b)", in_packet, wr_out);
    else n_pass++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    STP_IN[0] = 1'b1; END_IN[23] = 1'b1;
    step();
    n_total++; if (length !== LW'(6)) $display("FAIL basic_len: got %0h want 6", length); else n_pass++;
    n_total++; if (length_valid !== 16'h0001) $display("FAIL basic_valid: got %h want 0001", length_valid); else n_pass++;
    n_total++; if (pkt_count !== 16'd1) $display("FAIL basic_count: got %0d want 1", pkt_count); else n_pass++;
    n_total++; if (in_packet !== 1'b0) $display("FAIL basic_inpkt: got %0b want 0", in_packet); else n_pass++;
    idle_inputs();
    step();
    n_total++; if (length_valid !== '0 || length !== '0) $display("FAIL basic_cleared: valid %h len %0h want 0", length_valid, length); else n_pass++;
  endtask

  task automatic test_spanning();
    do_reset();
    STP_IN[60] = 1'b1;
    step();
    n_total++; if (in_packet !== 1'b1) $display("FAIL span_inpkt: got %0b want 1", in_packet); else n_pass++;
    n_total++; if (length_valid !== '0) $display("FAIL span_valid0: got %h want 0000", length_valid); else n_pass++;
    idle_inputs();
    END_IN[11] = 1'b1;
    step();
    n_total++; if (length !== LW'(4)) $display("FAIL span_len: got %0h want 4", length); else n_pass++;
    n_total++; if (length_valid !== 16'h0001) $display("FAIL span_valid: got %h want 0001", length_valid); else n_pass++;
    n_total++; if (in_packet !== 1'b0) $display("FAIL span_closed: got %0b want 0", in_packet); else n_pass++;
  endtask

  // Fifteen 4-byte packets, then two 1-byte packets: the sixteenth fills the
  // last slot with length 0 and the seventeenth has nowhere to go.
  task automatic test_too_many();
    logic [LW-1:0] want;
    do_reset();
    want = '0;
    for (int k = 0; k < 15; k++) begin
      STP_IN[4*k] = 1'b1; END_IN[4*k+3] = 1'b1;
      want[k*LEN_W +: LEN_W] = LEN_W'(1);
    end
    STP_IN[60] = 1'b1; END_IN[60] = 1'b1;
    STP_IN[61] = 1'b1; END_IN[61] = 1'b1;
    step();
    n_total++; if (length !== want) $display("FAIL many_len: got %0h want %0h", length, want); else n_pass++;
    n_total++; if (length_valid !== 16'hFFFF) $display("FAIL many_valid: got %h want ffff", length_valid); else n_pass++;
    n_total++; if (err_too_many !== 1'b1) $display("FAIL many_err: got %0b want 1", err_too_many); else n_pass++;
    n_total++; if (pkt_count !== 16'd16) $display("FAIL many_count: got %0d want 16", pkt_count); else n_pass++;
    n_total++; if (in_packet !== 1'b0 || err_no_end !== 1'b0) $display("FAIL many_closed: in_packet %0b err_no_end %0b want 0 0", in_packet, err_no_end); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    END_IN[5] = 1'b1; STP_IN[8] = 1'b1; STP_IN[20] = 1'b1; END_IN[27] = 1'b1;
    step();
    n_total++; if (err_no_stp !== 1'b1) $display("FAIL err_nostp: got %0b want 1", err_no_stp); else n_pass++;
    n_total++; if (err_no_end !== 1'b1) $display("FAIL err_noend: got %0b want 1", err_no_end); else n_pass++;
    n_total++; if (length !== LW'(2) || length_valid !== 16'h0001) $display("FAIL err_len: got %0h/%h want 2/0001", length, length_valid); else n_pass++;
    n_total++; if (pkt_count !== 16'd1) $display("FAIL err_count: got %0d want 1", pkt_count); else n_pass++;
    idle_inputs();
    step();
    n_total++; if ({err_no_stp, err_no_end, err_overflow, err_too_many} !== 4'b1100) $display("FAIL err_sticky: got %b want 1100", {err_no_stp, err_no_end, err_overflow, err_too_many}); else n_pass++;
  endtask

  task automatic test_skip_and_gen();
    do_reset();
    // Lanes 4..7 invalid, including an END marker that must be ignored.
    STP_IN[0] = 1'b1; END_IN[15] = 1'b1; END_IN[5] = 1'b1; wr_valid[7:4] = 4'b0000;
    step();
    n_total++; if (length !== LW'(3) || length_valid !== 16'h0001) $display("FAIL skip_len: got %0h/%h want 3/0001", length, length_valid); else n_pass++;
    // wr=0 holds an open packet across an idle cycle and ignores its markers.
    idle_inputs();
    STP_IN[60] = 1'b1;
    step();
    idle_inputs();
    wr = 1'b0; END_IN[3] = 1'b1;
    step();
    n_total++; if (in_packet !== 1'b1 || length_valid !== '0) $display("FAIL wr0_hold: in_packet %0b valid %h want 1 0000", in_packet, length_valid); else n_pass++;
    n_total++; if (wr_out !== 1'b0 || END_out !== 64'h8) $display("FAIL wr0_passthru: wr_out %0b END_out %h want 0 8", wr_out, END_out); else n_pass++;
    idle_inputs();
    END_IN[3] = 1'b1;
    step();
    n_total++; if (length !== LW'(2) || pkt_count !== 16'd2) $display("FAIL wr0_resume: len %0h count %0d want 2 2", length, pkt_count); else n_pass++;
    // Unsupported generation clears an open packet and reports nothing.
    idle_inputs();
    STP_IN[50] = 1'b1;
    step();
    idle_inputs();
    gen = 3'b010; STP_IN[0] = 1'b1; END_IN[23] = 1'b1; END_IN[30] = 1'b1;
    step();
    n_total++; if (length_valid !== '0 || pkt_count !== 16'd2 || in_packet !== 1'b0) $display("FAIL gen2: valid %h count %0d in_packet %0b want 0000 2 0", length_valid, pkt_count, in_packet); else n_pass++;
    n_total++; if (err_no_stp !== 1'b0) $display("FAIL gen2_noerr: got %0b want 0", err_no_stp); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    STP_IN[10] = 1'b1;
    step();
    n_total++; if (in_packet !== 1'b1) $display("FAIL midrst_open: got %0b want 1", in_packet); else n_pass++;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_total++;
    if ({data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out, length, length_valid,
         in_packet, pkt_count, err_no_stp, err_no_end, err_overflow, err_too_many} !== '0)
      $display("FAIL midrst_async: outputs not cleared (in_packet=%0b count=%0d)", in_packet, pkt_count);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
    n_total++; if (in_packet !== 1'b0 || length_valid !== '0) $display("FAIL midrst_after: in_packet %0b valid %h want 0 0000", in_packet, length_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic [8*BYTES-1:0] p_data;
    logic [BYTES-1:0]   p_stp, p_sdp;
    logic               p_wr;
    do_reset();
    m_open = 0; m_cnt = 0; m_pkts = 0; m_ns = 0; m_ne = 0; m_ov = 0; m_tm = 0;
    for (int c = 0; c < 300; c++) begin
      gen = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 5));
      wr  = ($urandom_range(0, 9) != 0);
      data_in = {16{$urandom()}};
      for (int i = 0; i < BYTES; i++) begin
        wr_valid[i] = ($urandom_range(0, 9) != 0);
        STP_IN[i]   = ($urandom_range(0, 15) == 0);
        SDP_IN[i]   = ($urandom_range(0, 15) == 0);
        END_IN[i]   = ($urandom_range(0, 13) == 0);
      end
      p_data = data_in; p_stp = STP_IN; p_sdp = SDP_IN; p_wr = wr;
      model_cycle();
      step();
      n_total++; if (length !== exp_len) $display("FAIL rnd_len c%0d: got %0h want %0h", c, length, exp_len); else n_pass++;
      n_total++; if (length_valid !== exp_lv) $display("FAIL rnd_valid c%0d: got %h want %h", c, length_valid, exp_lv); else n_pass++;
      n_total++; if (in_packet !== m_open) $display("FAIL rnd_inpkt c%0d: got %0b want %0b", c, in_packet, m_open); else n_pass++;
      n_total++; if (pkt_count !== 16'(m_pkts)) $display("FAIL rnd_count c%0d: got %0d want %0d", c, pkt_count, m_pkts); else n_pass++;
      n_total++;
      if ({err_no_stp, err_no_end, err_overflow, err_too_many} !== {m_ns, m_ne, m_ov, m_tm})
        $display("FAIL rnd_errs c%0d: got %b want %b", c, {err_no_stp, err_no_end, err_overflow, err_too_many}, {m_ns, m_ne, m_ov, m_tm});
      else n_pass++;
      n_total++;
      if (data_out !== p_data || STP_out !== p_stp || SDP_out !== p_sdp || wr_out !== p_wr)
        $display("FAIL rnd_passthru c%0d: data/marker delay mismatch wr_out %0b want %0b", c, wr_out, p_wr);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_spanning();
    test_too_many();
    test_errors();
    test_skip_and_gen();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
